// File: rtl/case1_pkg.sv
// Shared types and defaults for the case1 response compactor.
// Holds the FSM state encoding, the cone vector payload and the MISR tap helper.
package case1_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  localparam int unsigned DEF_SIG_W = 16;
  localparam int unsigned TAP_W     = 3;
  localparam logic [15:0] DEF_POLY  = 16'h1021;
  localparam logic [15:0] DEF_SEED  = 16'h0000;

  typedef struct packed {
    logic x;
    logic y;
    logic z;
  } cone_vec_t;

  // x lands on bit2, z on bit0 of the injected taps
  function automatic logic [TAP_W-1:0] misr_taps(input cone_vec_t v);
    return {v.x, v.y, v.z};
  endfunction

endpackage

// File: rtl/case1_misr.sv
// Multiple-input signature register with seed load and fold enable.
// Exposes the next-state value so the owner can compare the final signature early.
module case1_misr
  import case1_pkg::*;
#(
  parameter int unsigned      SIG_W = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [TAP_W-1:0] taps,
  output logic [SIG_W-1:0] sig,
  output logic [SIG_W-1:0] sig_nxt_c
);

  logic [SIG_W-1:0] fold_c;

  // Galois-style shift with polynomial feedback, then inject the cone taps
  always_comb begin
    fold_c    = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(taps);
    sig_nxt_c = sig;
    if (load) begin
      sig_nxt_c = SEED;
    end else if (en) begin
      sig_nxt_c = fold_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else begin
      sig <= sig_nxt_c;
    end
  end

endmodule

// File: rtl/case1_sig_capture.sv
// Response compactor for the case1 cone: folds NUM_VEC accepted {x,y,z} vectors
// into a MISR signature and reports a registered pass/fail against exp_sig.
module case1_sig_capture
  import case1_pkg::*;
#(
  parameter int unsigned      SIG_W   = DEF_SIG_W,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(DEF_SEED),
  parameter int unsigned      NUM_VEC = 16,
  parameter int unsigned      CNT_W   = $clog2(NUM_VEC + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             x,
  input  logic             y,
  input  logic             z,
  input  logic [SIG_W-1:0] exp_sig,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [SIG_W-1:0] sig_out,
  output logic             pass
);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             load_c;
  logic             accept_c;
  logic             last_c;
  cone_vec_t        vec_c;
  logic [SIG_W-1:0] sig_nxt_c;

  always_comb begin
    vec_c   = '0;
    vec_c.x = x;
    vec_c.y = y;
    vec_c.z = z;
  end

  // Next-state and run control; start is only honoured outside RUN
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_c   = 1'b0;
    accept_c = 1'b0;
    last_c   = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          load_c  = 1'b1;
        end
      end
      S_RUN: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_d == CNT_W'(NUM_VEC)) begin
            last_c  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      busy     <= 1'b0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      busy     <= (state_d == S_RUN);
      in_ready <= (state_d == S_RUN);
      done     <= (state_d == S_DONE);
      if (last_c) begin
        pass <= (sig_nxt_c == exp_sig);
      end else if (state_d != S_DONE) begin
        pass <= 1'b0;
      end
    end
  end

  assign vec_cnt = cnt_q;

  case1_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .en        (accept_c),
    .taps      (misr_taps(vec_c)),
    .sig       (sig_out),
    .sig_nxt_c (sig_nxt_c)
  );

endmodule
